// File: rtl/bullet_line_compositor.sv
// Scanline sprite engine: scans bullet RAM during hblank into a double-buffered
// slot table, then drives a registered per-pixel hit flag and colour.

module bullet_slot_cmp #(
    parameter int BULLET_SIZE = 8
) (
    input  logic       en,
    input  logic [8:0] xs,
    input  logic [9:0] x,
    output logic       hit
);
    logic [10:0] lo, hi, px;

    assign lo  = {2'b00, xs};
    assign hi  = lo + 11'(BULLET_SIZE);
    assign px  = {1'b0, x};
    assign hit = en && (px >= lo) && (px < hi);
endmodule

module bullet_line_compositor #(
    parameter int          MAX_BULLETS = 64,
    parameter int          NUM_SLOTS   = 8,
    parameter int          BULLET_SIZE = 8,
    parameter int          AW          = 6,
    parameter logic [11:0] COLOR_P1    = 12'hF00,
    parameter logic [11:0] COLOR_P2    = 12'h00F
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          frameStart,
    input  logic          lineStart,
    input  logic [9:0]    nextY,
    input  logic [9:0]    x,
    input  logic          active,
    output logic [AW-1:0] ramAddr,
    input  logic [31:0]   ramData,
    output logic          scanBusy,
    output logic          overflow,
    output logic          hit,
    output logic [11:0]   hitColor
);
    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam int SW = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

    state_t                          state;
    logic [9:0]                      ly;
    logic [1:0]                      vld_pipe;  // [0] address issued, [1] data returned
    logic                            front_sel;
    logic                            back;
    logic [1:0][CW-1:0]              cnt;
    logic [1:0][NUM_SLOTS-1:0][8:0]  slot_x;
    logic [1:0][NUM_SLOTS-1:0]       slot_own;

    logic [8:0]  wx, wy;
    logic        wown, wact, y_hit, take, room, issue_more;
    logic        unused_bits;

    assign wx          = ramData[31:23];
    assign wy          = ramData[22:14];
    assign wact        = ramData[5];
    assign wown        = ramData[4];
    assign unused_bits = ^{ramData[13:6], ramData[3:0]};
    assign back        = ~front_sel;

    // 11-bit sum so bullets near y=511 never wrap
    assign y_hit      = wact && ({2'b00, wy} <= {1'b0, ly}) &&
                        ({1'b0, ly} < ({2'b00, wy} + 11'(BULLET_SIZE)));
    assign take       = (state == SCAN) && vld_pipe[1] && !lineStart && y_hit;
    assign room       = cnt[back] < CW'(NUM_SLOTS);
    assign issue_more = vld_pipe[0] && (ramAddr != AW'(MAX_BULLETS - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ramAddr   <= '0;
            scanBusy  <= 1'b0;
            overflow  <= 1'b0;
            ly        <= '0;
            vld_pipe  <= '0;
            front_sel <= 1'b0;
            cnt       <= '0;
        end else begin
            if (take && !room)
                overflow <= 1'b1;
            else if (frameStart)
                overflow <= 1'b0;

            case (state)
                IDLE: begin
                    if (lineStart) begin
                        state     <= SCAN;
                        scanBusy  <= 1'b1;
                        ly        <= nextY;
                        ramAddr   <= '0;
                        vld_pipe  <= 2'b01;
                        cnt[back] <= '0;
                    end
                end
                SCAN: begin
                    if (lineStart) begin
                        ly        <= nextY;
                        ramAddr   <= '0;
                        vld_pipe  <= 2'b01;
                        cnt[back] <= '0;
                    end else begin
                        vld_pipe <= {vld_pipe[0], issue_more};
                        if (issue_more)
                            ramAddr <= ramAddr + AW'(1);
                        if (take && room)
                            cnt[back] <= cnt[back] + CW'(1);
                        if (vld_pipe == 2'b10) begin
                            state   <= SWAP;
                            ramAddr <= '0;
                        end
                    end
                end
                SWAP: begin
                    front_sel      <= back;
                    cnt[front_sel] <= '0;
                    scanBusy       <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slot payload needs no reset: only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (take && room) begin
            slot_x[back][cnt[back][SW-1:0]]   <= wx;
            slot_own[back][cnt[back][SW-1:0]] <= wown;
        end
    end

    logic [NUM_SLOTS-1:0] slot_hit;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        bullet_slot_cmp #(.BULLET_SIZE(BULLET_SIZE)) u_cmp (
            .en  (CW'(i) < cnt[front_sel]),
            .xs  (slot_x[front_sel][i]),
            .x   (x),
            .hit (slot_hit[i])
        );
    end

    logic any_hit, win_own;

    always_comb begin
        any_hit = 1'b0;
        win_own = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                any_hit = 1'b1;
                win_own = slot_own[front_sel][i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit      <= 1'b0;
            hitColor <= '0;
        end else if (active && any_hit) begin
            hit      <= 1'b1;
            hitColor <= win_own ? COLOR_P2 : COLOR_P1;
        end else begin
            hit      <= 1'b0;
            hitColor <= '0;
        end
    end
endmodule
